// File: rtl/m_cpu_bus_pkg.sv
// Shared types and constants for the 8088 local-bus memory responder.
// Holds the bus FSM state enum, bus widths and the default ROM boundary.
package m_cpu_bus_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ROM_BASE_DEF = 20'hC0000;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_HOLD,
    WR_WAIT,
    WR_HOLD
  } bus_state_e;

endpackage

// File: rtl/m_bus_addr_latch.sv
// ALE-transparent address register: follows addr_i on every clock while
// ale_i=1, holds otherwise. Ports: clk_i, rst_ni, ale_i, addr_i, addr_o.
module m_bus_addr_latch
  import m_cpu_bus_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ale_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
    end else if (ale_i) begin
      addr_q <= addr_i;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/m_cpu_mem_responder.sv
// 8088 local-bus memory responder: latches XA/XAD on ALE, answers memory
// read/write strobes with RAM Read/Write, fixed READY wait states, ROM write
// drop. Inputs: FCLK RESET XAD XA ALE RDL WRL IOM HLDA inRamData.
// Outputs: ABus Read Write outRamData cpuDIn READY RomWriteDrop.
module m_cpu_mem_responder
  import m_cpu_bus_pkg::*;
#(
  parameter int                WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0] ROM_BASE    = ROM_BASE_DEF
) (
  input  logic              FCLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] XAD,
  input  logic [11:0]       XA,
  input  logic              ALE,
  input  logic              RDL,
  input  logic              WRL,
  input  logic              IOM,
  input  logic              HLDA,
  input  logic [DATA_W-1:0] inRamData,
  output logic [ADDR_W-1:0] ABus,
  output logic              Read,
  output logic              Write,
  output logic [DATA_W-1:0] outRamData,
  output logic [DATA_W-1:0] cpuDIn,
  output logic              READY,
  output logic              RomWriteDrop
);

  localparam int CW =
    (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] WS_LD = CW'(WAIT_STATES);

  bus_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic read_q, read_d;
  logic write_q, write_d;
  logic ready_q, ready_d;
  logic drop_q, drop_d;
  logic [DATA_W-1:0] odat_q, odat_d;
  logic [DATA_W-1:0] cdin_q, cdin_d;
  logic prev_rdl_q, prev_wrl_q;

  logic [ADDR_W-1:0] addr;
  logic rd_fall, wr_fall;
  logic rom_hit, cnt_done;

  m_bus_addr_latch u_alat (
    .clk_i  (FCLK),
    .rst_ni (RESET),
    .ale_i  (ALE),
    .addr_i ({XA, XAD}),
    .addr_o (addr)
  );

  assign rd_fall  = prev_rdl_q & ~RDL;
  assign wr_fall  = prev_wrl_q & ~WRL;
  assign rom_hit  = (addr >= ROM_BASE);
  // Counter is loaded with N; the wait ends on the cycle it would hit 0.
  assign cnt_done = (cnt_q <= CW'(1));

  always_ff @(posedge FCLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      ready_q    <= 1'b1;
      drop_q     <= 1'b0;
      odat_q     <= '0;
      cdin_q     <= '0;
      prev_rdl_q <= 1'b1;
      prev_wrl_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      read_q     <= read_d;
      write_q    <= write_d;
      ready_q    <= ready_d;
      drop_q     <= drop_d;
      odat_q     <= odat_d;
      cdin_q     <= cdin_d;
      prev_rdl_q <= RDL;
      prev_wrl_q <= WRL;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    read_d  = read_q;
    write_d = write_q;
    ready_d = ready_q;
    drop_d  = 1'b0;
    odat_d  = odat_q;
    cdin_d  = cdin_q;

    if (HLDA) begin
      state_d = IDLE;
      cnt_d   = '0;
      read_d  = 1'b0;
      write_d = 1'b0;
      ready_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Read wins when both strobes fall together.
          if (!IOM && rd_fall) begin
            read_d = 1'b1;
            cnt_d  = WS_LD;
            if (WAIT_STATES == 0) begin
              state_d = RD_HOLD;
              cdin_d  = inRamData;
            end else begin
              state_d = RD_WAIT;
              ready_d = 1'b0;
            end
          end else if (!IOM && wr_fall) begin
            odat_d  = XAD;
            write_d = ~rom_hit;
            drop_d  = rom_hit;
            cnt_d   = WS_LD;
            if (WAIT_STATES == 0) begin
              state_d = WR_HOLD;
            end else begin
              state_d = WR_WAIT;
              ready_d = 1'b0;
            end
          end
        end
        RD_WAIT: begin
          if (RDL) begin
            state_d = IDLE;
            cnt_d   = '0;
            read_d  = 1'b0;
            ready_d = 1'b1;
          end else if (cnt_done) begin
            state_d = RD_HOLD;
            cnt_d   = '0;
            cdin_d  = inRamData;
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        RD_HOLD: begin
          if (RDL) begin
            state_d = IDLE;
            read_d  = 1'b0;
          end
        end
        WR_WAIT: begin
          if (WRL) begin
            state_d = IDLE;
            cnt_d   = '0;
            write_d = 1'b0;
            ready_d = 1'b1;
          end else if (cnt_done) begin
            state_d = WR_HOLD;
            cnt_d   = '0;
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        WR_HOLD: begin
          if (WRL) begin
            state_d = IDLE;
            write_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          read_d  = 1'b0;
          write_d = 1'b0;
          ready_d = 1'b1;
        end
      endcase
    end
  end

  assign ABus         = addr;
  assign Read         = read_q;
  assign Write        = write_q;
  assign READY        = ready_q;
  assign RomWriteDrop = drop_q;
  assign outRamData   = odat_q;
  assign cpuDIn       = cdin_q;

endmodule

// File: tb/tb_m_cpu_mem_responder.sv
// Self-checking bench for m_cpu_mem_responder (WAIT_STATES=2 and 0 builds).
// Directed vector table plus hand sequences for reset and zero-wait reads.
module tb_m_cpu_mem_responder;

  logic        FCLK = 1'b0;
  logic        RESET;
  logic [7:0]  XAD;
  logic [11:0] XA;
  logic        ALE, RDL, WRL, IOM, HLDA;
  logic [7:0]  inRamData;

  logic [19:0] ABus, z_ABus;
  logic        Read, Write, READY, RomWriteDrop;
  logic        z_Read, z_Write, z_READY, z_Drop;
  logic [7:0]  outRamData, cpuDIn, z_odat, z_cdin;

  int n_chk = 0;
  int n_fail = 0;

  always #5 FCLK = ~FCLK;

  m_cpu_mem_responder #(.WAIT_STATES(2)) dut (
    .FCLK(FCLK), .RESET(RESET), .XAD(XAD), .XA(XA), .ALE(ALE),
    .RDL(RDL), .WRL(WRL), .IOM(IOM), .HLDA(HLDA),
    .inRamData(inRamData), .ABus(ABus), .Read(Read), .Write(Write),
    .outRamData(outRamData), .cpuDIn(cpuDIn), .READY(READY),
    .RomWriteDrop(RomWriteDrop)
  );

  m_cpu_mem_responder #(.WAIT_STATES(0)) dut0 (
    .FCLK(FCLK), .RESET(RESET), .XAD(XAD), .XA(XA), .ALE(ALE),
    .RDL(RDL), .WRL(WRL), .IOM(IOM), .HLDA(HLDA),
    .inRamData(inRamData), .ABus(z_ABus), .Read(z_Read),
    .Write(z_Write), .outRamData(z_odat), .cpuDIn(z_cdin),
    .READY(z_READY), .RomWriteDrop(z_Drop)
  );

  typedef struct {
    logic        ale;
    logic [11:0] xa;
    logic [7:0]  xad;
    logic        rdl, wrl, iom, hlda;
    logic [7:0]  ram;
    logic [39:0] exp;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    logic ale, logic [11:0] xa, logic [7:0] xad,
    logic rdl, logic wrl, logic iom, logic hlda, logic [7:0] ram,
    logic [19:0] ab, logic rd, logic wr, logic rdy, logic drp,
    logic [7:0] cd, logic [7:0] od);
    vec_t v;
    v.ale = ale; v.xa = xa; v.xad = xad;
    v.rdl = rdl; v.wrl = wrl; v.iom = iom; v.hlda = hlda;
    v.ram = ram;
    v.exp = {ab, rd, wr, rdy, drp, cd, od};
    return v;
  endfunction

  function automatic logic [39:0] outs();
    return {ABus, Read, Write, READY, RomWriteDrop, cpuDIn, outRamData};
  endfunction

  task automatic chk(string nm, logic [39:0] act, logic [39:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge FCLK);
    #1;
  endtask

  task automatic idle_in();
    ALE = 0; XA = '0; XAD = '0; RDL = 1; WRL = 1;
    IOM = 0; HLDA = 0; inRamData = '0;
  endtask

  initial begin
    // read 01234, 2 waits
    tv.push_back(mk(1,'h012,'h34,1,1,0,0,'h00,'h01234,0,0,1,0,'h00,'h00));
    tv.push_back(mk(0,'h012,'h00,0,1,0,0,'hA5,'h01234,1,0,0,0,'h00,'h00));
    tv.push_back(mk(0,'h012,'h00,0,1,0,0,'hA5,'h01234,1,0,0,0,'h00,'h00));
    tv.push_back(mk(0,'h012,'h00,0,1,0,0,'hA5,'h01234,1,0,1,0,'hA5,'h00));
    tv.push_back(mk(0,'h012,'h00,0,1,0,0,'h00,'h01234,1,0,1,0,'hA5,'h00));
    tv.push_back(mk(0,'h012,'h00,1,1,0,0,'h00,'h01234,0,0,1,0,'hA5,'h00));
    tv.push_back(mk(0,'h012,'h00,1,1,0,0,'h00,'h01234,0,0,1,0,'hA5,'h00));
    // RAM write 00100 <= 3C
    tv.push_back(mk(1,'h001,'h00,1,1,0,0,'h00,'h00100,0,0,1,0,'hA5,'h00));
    tv.push_back(mk(0,'h001,'h3C,1,0,0,0,'h00,'h00100,0,1,0,0,'hA5,'h3C));
    tv.push_back(mk(0,'h001,'h3C,1,0,0,0,'h00,'h00100,0,1,0,0,'hA5,'h3C));
    tv.push_back(mk(0,'h001,'h3C,1,0,0,0,'h00,'h00100,0,1,1,0,'hA5,'h3C));
    tv.push_back(mk(0,'h001,'h3C,1,1,0,0,'h00,'h00100,0,0,1,0,'hA5,'h3C));
    // ROM write C0000 <= FF, dropped
    tv.push_back(mk(1,'hC00,'h00,1,1,0,0,'h00,'hC0000,0,0,1,0,'hA5,'h3C));
    tv.push_back(mk(0,'hC00,'hFF,1,0,0,0,'h00,'hC0000,0,0,0,1,'hA5,'hFF));
    tv.push_back(mk(0,'hC00,'hFF,1,0,0,0,'h00,'hC0000,0,0,0,0,'hA5,'hFF));
    tv.push_back(mk(0,'hC00,'hFF,1,0,0,0,'h00,'hC0000,0,0,1,0,'hA5,'hFF));
    tv.push_back(mk(0,'hC00,'hFF,1,1,0,0,'h00,'hC0000,0,0,1,0,'hA5,'hFF));
    // I/O read ignored
    tv.push_back(mk(0,'hC00,'h00,0,1,1,0,'h11,'hC0000,0,0,1,0,'hA5,'hFF));
    tv.push_back(mk(0,'hC00,'h00,0,1,1,0,'h11,'hC0000,0,0,1,0,'hA5,'hFF));
    tv.push_back(mk(0,'hC00,'h00,1,1,1,0,'h11,'hC0000,0,0,1,0,'hA5,'hFF));
    tv.push_back(mk(0,'hC00,'h00,1,1,0,0,'h00,'hC0000,0,0,1,0,'hA5,'hFF));
    // HLDA during RD_WAIT
    tv.push_back(mk(0,'hC00,'h00,0,1,0,0,'h77,'hC0000,1,0,0,0,'hA5,'hFF));
    tv.push_back(mk(0,'hC00,'h00,0,1,0,1,'h77,'hC0000,0,0,1,0,'hA5,'hFF));
    tv.push_back(mk(0,'hC00,'h00,0,1,0,0,'h77,'hC0000,0,0,1,0,'hA5,'hFF));
    tv.push_back(mk(0,'hC00,'h00,1,1,0,0,'h00,'hC0000,0,0,1,0,'hA5,'hFF));
    // RDL rises during wait: abort, no capture
    tv.push_back(mk(0,'hC00,'h00,0,1,0,0,'h99,'hC0000,1,0,0,0,'hA5,'hFF));
    tv.push_back(mk(0,'hC00,'h00,1,1,0,0,'h99,'hC0000,0,0,1,0,'hA5,'hFF));
    // both strobes fall: read wins
    tv.push_back(mk(0,'hC00,'h11,0,0,0,0,'h42,'hC0000,1,0,0,0,'hA5,'hFF));
    tv.push_back(mk(0,'hC00,'h11,0,0,0,0,'h42,'hC0000,1,0,0,0,'hA5,'hFF));
    tv.push_back(mk(0,'hC00,'h11,0,0,0,0,'h42,'hC0000,1,0,1,0,'h42,'hFF));
    tv.push_back(mk(0,'hC00,'h11,1,1,0,0,'h00,'hC0000,0,0,1,0,'h42,'hFF));

    idle_in();
    RESET = 0;
    repeat (2) @(posedge FCLK);
    #1;
    chk("reset_state", outs(), {20'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 8'h0});
    @(negedge FCLK);
    RESET = 1;
    #1;

    foreach (tv[i]) begin
      ALE = tv[i].ale; XA = tv[i].xa; XAD = tv[i].xad;
      RDL = tv[i].rdl; WRL = tv[i].wrl; IOM = tv[i].iom;
      HLDA = tv[i].hlda; inRamData = tv[i].ram;
      tick();
      chk($sformatf("vec%0d", i), outs(), tv[i].exp);
    end

    // zero-wait build: read FFFFF returns 5A with READY never low
    idle_in();
    ALE = 1; XA = 12'hFFF; XAD = 8'hFF;
    tick();
    chk("ws0_abus", {20'h0, z_ABus}, {20'h0, 20'hFFFFF});
    ALE = 0; XAD = 8'h00; RDL = 0; inRamData = 8'h5A;
    tick();
    chk("ws0_rd1", {37'h0, z_Read, z_READY, z_Write}, {37'h0, 3'b110});
    chk("ws0_cdin", {32'h0, z_cdin}, {32'h0, 8'h5A});
    inRamData = 8'h00;
    tick();
    chk("ws0_hold", {32'h0, z_Read, z_READY, z_cdin, 6'h0},
        {32'h0, 1'b1, 1'b1, 8'h5A, 6'h0});
    RDL = 1;
    tick();
    chk("ws0_end", {38'h0, z_Read, z_READY}, {38'h0, 2'b01});

    // reset asserted during WR_WAIT
    ALE = 1; XA = 12'h002; XAD = 8'h00;
    tick();
    ALE = 0; XAD = 8'h5D; WRL = 0;
    tick();
    chk("wr_wait", {38'h0, Write, READY}, {38'h0, 2'b10});
    #2;
    RESET = 0;
    #1;
    chk("async_rst", outs(), {20'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h42, 8'h0} &
        {20'hFFFFF, 4'hF, 8'h0, 8'hFF});
    chk("async_rst_cd", {32'h0, cpuDIn}, 40'h0);
    WRL = 1;
    @(negedge FCLK);
    RESET = 1;
    ALE = 1; XA = 12'h003; XAD = 8'h00;
    tick();
    chk("post_abus", {20'h0, ABus}, {20'h0, 20'h00300});
    ALE = 0; RDL = 0; inRamData = 8'hC3;
    tick();
    chk("post_rd_w1", {38'h0, Read, READY}, {38'h0, 2'b10});
    tick();
    chk("post_rd_w2", {38'h0, Read, READY}, {38'h0, 2'b10});
    tick();
    chk("post_rd_dat", {30'h0, Read, READY, cpuDIn},
        {30'h0, 2'b11, 8'hC3});
    RDL = 1;
    tick();
    chk("post_rd_end", {38'h0, Read, READY}, {38'h0, 2'b01});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
